// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared scan states, column map and sizes for the matrix scanner
package matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int COL_W    = 3;
  localparam int ROW_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Columns 0/4 and 1/3 share a row multiplexer group; column 2 has its own.
  function automatic logic [2:0] ring_for_col(input logic [COL_W-1:0] col);
    case (col)
      3'd0, 3'd4: return 3'b100;
      3'd1, 3'd3: return 3'b010;
      3'd2:       return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/matrix_frame_buffer.sv
// rtl/matrix_frame_buffer.sv - shadow/active row data pair with pending flag
module matrix_frame_buffer
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             apply,
  input  logic [ROW_W-1:0] next_col_2,
  input  logic [ROW_W-1:0] next_col_1,
  input  logic [ROW_W-1:0] next_col_0,
  output logic [ROW_W-1:0] col_2,
  output logic [ROW_W-1:0] col_1,
  output logic [ROW_W-1:0] col_0,
  output logic             load_ack
);

  logic [ROW_W-1:0] shadow_2;
  logic [ROW_W-1:0] shadow_1;
  logic [ROW_W-1:0] shadow_0;
  logic             pending;

  // Promote the shadow only if it was pending before this boundary; a load on
  // the boundary itself lands in the shadow and waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_2 <= '0;
      shadow_1 <= '0;
      shadow_0 <= '0;
      col_2    <= '0;
      col_1    <= '0;
      col_0    <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= apply && pending;
      if (apply && pending) begin
        col_2 <= shadow_2;
        col_1 <= shadow_1;
        col_0 <= shadow_0;
      end
      if (load) begin
        shadow_2 <= next_col_2;
        shadow_1 <= next_col_1;
        shadow_0 <= next_col_0;
        pending  <= 1'b1;
      end else if (apply) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_controller.sv
// rtl/matrix_scan_controller.sv - five-column LED matrix scan FSM with frame-synchronous data swap
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [ROW_W-1:0] next_col_2,
  input  logic [ROW_W-1:0] next_col_1,
  input  logic [ROW_W-1:0] next_col_0,
  output logic [2:0]       ring_counter,
  output logic [ROW_W-1:0] col_2,
  output logic [ROW_W-1:0] col_1,
  output logic [ROW_W-1:0] col_0,
  output logic [4:0]       col_en_n,
  output logic             frame_start,
  output logic             load_ack
);

  localparam logic [15:0]      BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0]      DRIVE_LAST = 16'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

  scan_state_t      state;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] next_col;
  logic [15:0]      dwell;
  logic             frame_enter;

  assign next_col = (col == LAST_COL) ? '0 : col + 1'b1;

  // Edges that land in the first blank cycle of column 0: start-up or wrap.
  assign frame_enter = enable &&
                       ((state == ST_IDLE) ||
                        (state == ST_DRIVE && dwell == DRIVE_LAST && col == LAST_COL));

  // Scan FSM with registered column enables, group select and frame pulse.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state        <= ST_IDLE;
      col          <= '0;
      dwell        <= '0;
      ring_counter <= 3'b000;
      col_en_n     <= 5'b11111;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          state        <= ST_BLANK;
          col          <= '0;
          dwell        <= '0;
          ring_counter <= ring_for_col('0);
          col_en_n     <= 5'b11111;
          frame_start  <= 1'b1;
        end
        ST_BLANK: begin
          if (dwell == BLANK_LAST) begin
            state    <= ST_DRIVE;
            dwell    <= '0;
            col_en_n <= ~(5'd1 << col);
          end else begin
            dwell <= dwell + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (dwell == DRIVE_LAST) begin
            state        <= ST_BLANK;
            dwell        <= '0;
            col          <= next_col;
            ring_counter <= ring_for_col(next_col);
            col_en_n     <= 5'b11111;
            frame_start  <= (next_col == '0);
          end else begin
            dwell <= dwell + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          dwell <= '0;
        end
      endcase
    end
  end

  matrix_frame_buffer u_frame_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .apply      (frame_enter),
    .next_col_2 (next_col_2),
    .next_col_1 (next_col_1),
    .next_col_0 (next_col_0),
    .col_2      (col_2),
    .col_1      (col_1),
    .col_0      (col_0),
    .load_ack   (load_ack)
  );

endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb/tb_matrix_scan_controller.sv - randomized scoreboard bench for matrix_scan_controller
module tb_matrix_scan_controller;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = 5 * CLK_DIV;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [6:0] next_col_2, next_col_1, next_col_0;
  logic [2:0] ring_counter;
  logic [6:0] col_2, col_1, col_0;
  logic [4:0] col_en_n;
  logic       frame_start;
  logic       load_ack;

  matrix_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .next_col_2   (next_col_2),
    .next_col_1   (next_col_1),
    .next_col_0   (next_col_0),
    .ring_counter (ring_counter),
    .col_2        (col_2),
    .col_1        (col_1),
    .col_0        (col_0),
    .col_en_n     (col_en_n),
    .frame_start  (frame_start),
    .load_ack     (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ring;
    logic [4:0] en_n;
    logic       fs;
    logic       ack;
    logic [6:0] c2;
    logic [6:0] c1;
    logic [6:0] c0;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: position within the frame since the scan started.
  bit         m_run  = 0;
  int         m_p    = 0;
  bit         m_pend = 0;
  logic [6:0] m_sh2 = 0, m_sh1 = 0, m_sh0 = 0;
  logic [6:0] m_a2 = 0, m_a1 = 0, m_a0 = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ld,
                      input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    exp_t e;
    bit   ack;
    int   c;
    bit   blank;
    ack = 0;
    reset = rst; enable = en; load = ld;
    next_col_2 = d2; next_col_1 = d1; next_col_0 = d0;
    if (rst) begin
      m_run = 0; m_p = 0; m_pend = 0;
      m_sh2 = 0; m_sh1 = 0; m_sh0 = 0;
      m_a2 = 0; m_a1 = 0; m_a0 = 0;
    end else begin
      if (!en) m_run = 0;
      else begin
        if (!m_run) begin m_run = 1; m_p = 0; end
        else m_p = (m_p + 1) % FRAME;
        if (m_p == 0 && m_pend) begin
          m_a2 = m_sh2; m_a1 = m_sh1; m_a0 = m_sh0;
          m_pend = 0; ack = 1;
        end
      end
      if (ld) begin
        m_sh2 = d2; m_sh1 = d1; m_sh0 = d0; m_pend = 1;
      end
    end
    if (m_run) begin
      c = m_p / CLK_DIV;
      blank = (m_p % CLK_DIV) < BLANK;
      e.ring = (c == 2) ? 3'b001 : ((c == 1 || c == 3) ? 3'b010 : 3'b100);
      e.en_n = blank ? 5'b11111 : 5'(~(32'd1 << c));
      e.fs   = (m_p == 0);
    end else begin
      e.ring = 3'b000;
      e.en_n = 5'b11111;
      e.fs   = 1'b0;
    end
    e.ack = ack;
    e.c2 = m_a2; e.c1 = m_a1; e.c0 = m_a0;
    @(posedge clk);
    #1;
    cyc++;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 7'($urandom), 7'($urandom), 7'($urandom));
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (!m_run || m_p != target) begin
      step(0, 1, 0, 7'($urandom), 7'($urandom), 7'($urandom));
      guard++;
      if (guard > 3 * FRAME) begin
        n_tests++; n_fail++;
        $display("FAIL run_to_timeout target=%0d", target);
        break;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ring_counter", 8'(ring_counter), 8'(e.ring));
        chk("col_en_n",     8'(col_en_n),     8'(e.en_n));
        chk("frame_start",  8'(frame_start),  8'(e.fs));
        chk("load_ack",     8'(load_ack),     8'(e.ack));
        chk("col_2",        8'(col_2),        8'(e.c2));
        chk("col_1",        8'(col_1),        8'(e.c1));
        chk("col_0",        8'(col_0),        8'(e.c0));
      end
    end
  end

  initial begin
    int guard;
    reset = 1; enable = 0; load = 0;
    next_col_2 = 0; next_col_1 = 0; next_col_0 = 0;
    #2;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 7'h0, 7'h0, 7'h0);
    // Basic scan from reset
    run(45);
    // Mid-frame load
    run_to(8);
    step(0, 1, 1, 7'h55, 7'h2a, 7'h13);
    run(30);
    // Load on the boundary edge
    run_to(FRAME - 1);
    step(0, 1, 1, 7'h33, 7'h44, 7'h66);
    run(45);
    // Two loads in one frame
    run_to(3);
    step(0, 1, 1, 7'h11, 7'h01, 7'h02);
    run_to(9);
    step(0, 1, 1, 7'h22, 7'h03, 7'h04);
    run(30);
    // Enable dropped during drive of column 2, then re-enabled
    run_to(2 * CLK_DIV + 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 7'h0, 7'h0, 7'h0);
    run(25);
    // Leave idle with a pending load
    step(0, 0, 1, 7'h7f, 7'h5a, 7'h0f);
    step(0, 0, 0, 7'h0, 7'h0, 7'h0);
    run(25);
    // Reset with load pending while enabled
    run_to(6);
    step(0, 1, 1, 7'h6b, 7'h1c, 7'h3d);
    step(1, 1, 0, 7'h0, 7'h0, 7'h0);
    run(45);
    // Randomized traffic, biased toward boundary loads
    for (int i = 0; i < 2500; i++) begin
      bit en, ld, rst;
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 63) != 0);
      if (m_run && m_p == FRAME - 1) ld = $urandom_range(0, 1);
      else                           ld = ($urandom_range(0, 11) == 0);
      step(rst, en, ld, 7'($urandom), 7'($urandom), 7'($urandom));
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain left=%0d", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
